// File: rtl/bw_bridge_pkg.sv
// bw_bridge_pkg: shared widths, FSM state encoding and grant-source encoding for the regfile arbiter
package bw_bridge_pkg;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
  typedef struct packed {
    logic             host;
    logic [IDX_W-1:0] idx;
  } gnt_src_t;
endpackage

// File: rtl/gpmc_regfile_arbiter_if.sv
// gpmc_regfile_arbiter_if: host, internal-requester and register-file signals; slave = arbiter, master = surroundings
interface gpmc_regfile_arbiter_if
  import bw_bridge_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                          host_valid;
  logic                          host_we;
  logic [ADDR_WIDTH-1:0]         host_addr;
  logic [DATA_WIDTH-1:0]         host_wdata;
  logic                          host_ack;
  logic [DATA_WIDTH-1:0]         host_rdata;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         req_rdata;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          busy;
  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output host_ack, host_rdata, req_ack, req_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  host_ack, host_rdata, req_ack, req_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req_i/ptr_i in, one-hot gnt_o, index idx_o and any_o out
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  logic [NUM_REQ-1:0] rot;
  int k_sel;
  int sum;
  // rotate so bit 0 is the requester at ptr_i, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = NUM_REQ'({req_i, req_i} >> ptr_i);
    k_sel = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) k_sel = rot[k] ? k : k_sel;
    sum = int'(ptr_i) + k_sel;
    idx_o = IW'(sum >= NUM_REQ ? sum - NUM_REQ : sum);
    any_o = |req_i;
    gnt_o = any_o ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/gpmc_regfile_arbiter.sv
// gpmc_regfile_arbiter: shares the register file between the host (absolute priority) and NUM_REQ round-robin requesters
module gpmc_regfile_arbiter
  import bw_bridge_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic clk,
  input logic rst_n,
  gpmc_regfile_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state_q, state_d;
  gnt_src_t gnt_q, gnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic arb_any;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d, req_rdata_q, req_rdata_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i(bus.req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .any_o(arb_any)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      host_rdata_q <= '0;
      req_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      host_rdata_q <= host_rdata_d;
      req_rdata_q  <= req_rdata_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    host_rdata_d = host_rdata_q;
    req_rdata_d  = req_rdata_q;
    case (state_q)
      IDLE:
        if (bus.host_valid) begin
          state_d  = ISSUE;
          gnt_d    = '{host: 1'b1, idx: '0};
          we_d     = bus.host_we;
          addr_d   = bus.host_addr;
          wdata_d  = bus.host_wdata;
        end else if (arb_any) begin
          state_d  = ISSUE;
          gnt_d    = '{host: 1'b0, idx: IDX_W'(arb_idx)};
          rr_ptr_d = arb_idx == IW'(NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          for (int i = 0; i < NUM_REQ; i++)
            if (arb_gnt[i]) begin
              we_d    = bus.req_we[i];
              addr_d  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d = DONE;
        // each side keeps its own last read value so the other side's traffic cannot disturb it
        if (gnt_q.host) host_rdata_d = bus.mem_rdata;
        else req_rdata_d = bus.mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.mem_en     = state_q == ISSUE;
    bus.mem_we     = state_q == ISSUE && we_q;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    bus.host_ack   = state_q == DONE && gnt_q.host;
    bus.req_ack    = (state_q == DONE && !gnt_q.host) ? NUM_REQ'(1) << gnt_q.idx : '0;
    bus.host_rdata = host_rdata_q;
    bus.req_rdata  = req_rdata_q;
    bus.busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_gpmc_regfile_arbiter.sv
// tb_gpmc_regfile_arbiter: table-driven transaction checks plus reset-abort sequences for gpmc_regfile_arbiter
module tb_gpmc_regfile_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic seen;
  always #5 clk = ~clk;
  gpmc_regfile_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();
  gpmc_regfile_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  logic [15:0] mem [16];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  int total = 0;
  int passed = 0;
  typedef struct {
    logic        hv, hwe;
    logic [3:0]  haddr;
    logic [15:0] hwd;
    logic [3:0]  rv, rwe, raddr;
    logic [15:0] rwd;
    logic        eh;
    logic [3:0]  er;
    logic        cd;
    logic [15:0] ed;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic idle_bus();
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.req_valid  = '0;
    bus.req_we     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
  endtask
  task automatic run(input int n, input vec_t v);
    int lat;
    logic got;
    logic mwe;
    logic [3:0] maddr;
    logic [15:0] mwd;
    mwe = v.hwe;
    maddr = v.haddr;
    mwd = v.hwd;
    if (!v.eh) begin
      maddr = v.raddr;
      mwd = v.rwd;
      for (int i = 0; i < 4; i++) if (v.er[i]) mwe = v.rwe[i];
    end
    @(negedge clk);
    bus.host_valid = v.hv;
    bus.host_we    = v.hwe;
    bus.host_addr  = v.haddr;
    bus.host_wdata = v.hwd;
    bus.req_valid  = v.rv;
    bus.req_we     = v.rwe;
    bus.req_addr   = {4{v.raddr}};
    bus.req_wdata  = {4{v.rwd}};
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk($sformatf("v%0d mem_en", n), 32'(bus.mem_en), 32'(1'b1));
        chk($sformatf("v%0d mem_we", n), 32'(bus.mem_we), 32'(mwe));
        chk($sformatf("v%0d mem_addr", n), 32'(bus.mem_addr), 32'(maddr));
        if (mwe) chk($sformatf("v%0d mem_wdata", n), 32'(bus.mem_wdata), 32'(mwd));
        chk($sformatf("v%0d busy", n), 32'(bus.busy), 32'(1'b1));
      end
      got = bus.host_ack || (bus.req_ack != 4'b0);
    end
    chk($sformatf("v%0d latency", n), 32'(lat), 32'd3);
    chk($sformatf("v%0d host_ack", n), 32'(bus.host_ack), 32'(v.eh));
    chk($sformatf("v%0d req_ack", n), 32'(bus.req_ack), 32'(v.er));
    if (v.cd) chk($sformatf("v%0d rdata", n), 32'(v.eh ? bus.host_rdata : bus.req_rdata), 32'(v.ed));
    idle_bus();
  endtask
  initial begin
    idle_bus();
    rst_n = 1'b0;
    tbl[0]  = '{1'b1, 1'b1, 4'h3, 16'hBEEF, 4'h0, 4'h0, 4'h0, 16'h0,    1'b1, 4'h0, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h3, 16'h0,    4'h0, 4'h0, 4'h0, 16'h0,    1'b1, 4'h0, 1'b1, 16'hBEEF};
    tbl[2]  = '{1'b0, 1'b0, 4'h0, 16'h0,    4'hF, 4'h0, 4'h3, 16'h0,    1'b0, 4'h1, 1'b1, 16'hBEEF};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 16'h0,    4'hF, 4'h0, 4'h3, 16'h0,    1'b0, 4'h2, 1'b1, 16'hBEEF};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 16'h0,    4'hF, 4'h0, 4'h3, 16'h0,    1'b0, 4'h4, 1'b1, 16'hBEEF};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 16'h0,    4'hF, 4'h0, 4'h3, 16'h0,    1'b0, 4'h8, 1'b1, 16'hBEEF};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 16'h0,    4'hF, 4'h0, 4'h3, 16'h0,    1'b0, 4'h1, 1'b1, 16'hBEEF};
    tbl[7]  = '{1'b1, 1'b0, 4'h3, 16'h0,    4'h4, 4'h0, 4'h3, 16'h0,    1'b1, 4'h0, 1'b1, 16'hBEEF};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 16'h0,    4'h4, 4'h0, 4'h3, 16'h0,    1'b0, 4'h4, 1'b1, 16'hBEEF};
    tbl[9]  = '{1'b1, 1'b0, 4'h3, 16'h0,    4'hF, 4'h0, 4'h3, 16'h0,    1'b1, 4'h0, 1'b1, 16'hBEEF};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 16'h0,    4'hB, 4'h0, 4'h3, 16'h0,    1'b0, 4'h8, 1'b1, 16'hBEEF};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 16'h0,    4'h2, 4'h2, 4'h0, 16'h000A, 1'b0, 4'h2, 1'b0, 16'h0};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 16'h0,    4'h8, 4'h0, 4'h0, 16'h0,    1'b0, 4'h8, 1'b1, 16'h000A};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 16'h0,    4'h0, 4'h0, 4'h0, 16'h0,    1'b1, 4'h0, 1'b1, 16'h000A};
    tbl[14] = '{1'b1, 1'b0, 4'h7, 16'h0,    4'h0, 4'h0, 4'h0, 16'h0,    1'b1, 4'h0, 1'b1, 16'h5555};
    tbl[15] = '{1'b1, 1'b0, 4'h3, 16'h0,    4'h0, 4'h0, 4'h0, 16'h0,    1'b1, 4'h0, 1'b1, 16'hBEEF};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst host_rdata", 32'(bus.host_rdata), 32'h0);
    chk("rst req_rdata", 32'(bus.req_rdata), 32'h0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d busy/en/acks", c), {28'b0, bus.busy, bus.mem_en, bus.host_ack, |bus.req_ack}, 32'h0);
    end
    for (int n = 0; n < 14; n++) run(n, tbl[n]);
    chk("mem0 low nibble", 32'(mem[0][3:0]), 32'hA);
    @(negedge clk);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 4'h7;
    bus.host_wdata = 16'h5555;
    @(negedge clk);
    chk("issue-reset mem_we", 32'(bus.mem_we), 32'(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bus();
    chk("issue-reset busy", 32'(bus.busy), 32'h0);
    seen = bus.host_ack;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.host_ack;
    end
    chk("issue-reset no ack", 32'(seen), 32'h0);
    @(negedge clk);
    bus.host_valid = 1'b1;
    bus.host_addr  = 4'h3;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bus();
    chk("capture-reset busy", 32'(bus.busy), 32'h0);
    chk("capture-reset host_rdata", 32'(bus.host_rdata), 32'h0);
    seen = bus.host_ack;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.host_ack;
    end
    chk("capture-reset no ack", 32'(seen), 32'h0);
    run(14, tbl[14]);
    run(15, tbl[15]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
